// File: rtl/pingpong_sram_array.sv
// pingpong_sram_array
//   Double-buffered (ping-pong) SRAM between the rasteriser and the display.
//   Producers write the back bank through per-channel write ports while
//   consumers read the front bank through per-channel read ports. A level
//   flip request swaps the banks and is answered with a one-cycle ack.
//
//   Optional feature: define PINGPONG_SRAM_CLEAR_EN to clear the new back
//   bank to CLEAR_VALUE (one word per cycle) after every flip, before the ack.
//
// Ports
//   i_clk, i_rst       clock (rising edge), async active-high reset
//   i_wr_en/addr/data  per-channel back-bank writes (lowest channel wins on
//                      same-address collisions, addr >= DEPTH ignored)
//   o_wr_ready         writes accepted this cycle (low while clearing)
//   i_rd_en/addr       per-channel front-bank reads, 1-cycle latency
//   o_rd_data/valid    read results (addr >= DEPTH reads 0, valid)
//   i_flip_req         level request to swap banks
//   o_flip_ack         one-cycle pulse when the flip is complete
//   o_busy             clear in progress
//   o_front_sel        index of the current front (read) bank

module pingpong_sram_array #(
  parameter int                   CHANNELS    = 4,
  parameter int                   DATA_SIZE   = 16,
  parameter int                   ADDR_SIZE   = 10,
  parameter int                   DEPTH       = 1024,
  parameter logic [DATA_SIZE-1:0] CLEAR_VALUE = '0
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [CHANNELS-1:0]                 i_wr_en,
  input  logic [CHANNELS-1:0][ADDR_SIZE-1:0]  i_wr_addr,
  input  logic [CHANNELS-1:0][DATA_SIZE-1:0]  i_wr_data,
  output logic                                o_wr_ready,
  input  logic [CHANNELS-1:0]                 i_rd_en,
  input  logic [CHANNELS-1:0][ADDR_SIZE-1:0]  i_rd_addr,
  output logic [CHANNELS-1:0][DATA_SIZE-1:0]  o_rd_data,
  output logic [CHANNELS-1:0]                 o_rd_valid,
  input  logic                                i_flip_req,
  output logic                                o_flip_ack,
  output logic                                o_busy,
  output logic                                o_front_sel
);

  localparam int                   IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_SIZE:0]   DEPTH_C = (ADDR_SIZE+1)'(DEPTH);

  // state  | meaning
  // IDLE   | waiting for a flip request
  // CLEAR  | writing CLEAR_VALUE over the new back bank (macro only)
  // ACK    | flip complete, o_flip_ack high for this cycle
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK   = 2'd2
`ifdef PINGPONG_SRAM_CLEAR_EN
    ,S_CLEAR = 2'd1
`endif
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;
  logic   r_front_sel;

  logic [DATA_SIZE-1:0] r_bank0 [DEPTH];
  logic [DATA_SIZE-1:0] r_bank1 [DEPTH];

  logic [CHANNELS-1:0][DATA_SIZE-1:0] r_rd_data;
  logic [CHANNELS-1:0]                r_rd_valid;

  function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
    return {1'b0, a} < DEPTH_C;
  endfunction

`ifdef PINGPONG_SRAM_CLEAR_EN
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  logic [IW-1:0] r_clr_ptr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clr_ptr <= '0;
    end else if (w_accept) begin
      r_clr_ptr <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_ptr <= r_clr_ptr + IW'(1);
    end
  end

  assign o_busy     = (r_state == S_CLEAR);
  assign o_wr_ready = (r_state != S_CLEAR);
`else
  logic w_unused_clear;
  assign w_unused_clear = ^CLEAR_VALUE;
  assign o_busy         = 1'b0;
  assign o_wr_ready     = 1'b1;
`endif

  assign o_flip_ack  = (r_state == S_ACK);
  assign o_front_sel = r_front_sel;
  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_front_sel <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_front_sel <= ~r_front_sel;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_flip_req && !o_flip_ack) begin
          w_accept = 1'b1;
`ifdef PINGPONG_SRAM_CLEAR_EN
          w_state_nxt = S_CLEAR;
`else
          w_state_nxt = S_ACK;
`endif
        end
      end
`ifdef PINGPONG_SRAM_CLEAR_EN
      S_CLEAR: if (r_clr_ptr == LAST) w_state_nxt = S_ACK;
`endif
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Back bank is ~r_front_sel. At the accepting edge r_front_sel still holds
  // the old value, so writes sampled there land in the old back bank.
  // Channels are visited high to low so the lowest channel's write is the
  // last assignment and wins a same-address collision.
  always_ff @(posedge i_clk) begin
`ifdef PINGPONG_SRAM_CLEAR_EN
    if (r_state == S_CLEAR) begin
      if (r_front_sel) r_bank0[r_clr_ptr] <= CLEAR_VALUE;
      else             r_bank1[r_clr_ptr] <= CLEAR_VALUE;
    end
`endif
    if (o_wr_ready) begin
      for (int c = CHANNELS - 1; c >= 0; c--) begin
        if (i_wr_en[c] && in_range(i_wr_addr[c])) begin
          if (r_front_sel) r_bank0[i_wr_addr[c][IW-1:0]] <= i_wr_data[c];
          else             r_bank1[i_wr_addr[c][IW-1:0]] <= i_wr_data[c];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= '0;
    end else begin
      r_rd_valid <= i_rd_en;
      for (int c = 0; c < CHANNELS; c++) begin
        if (i_rd_en[c]) begin
          if (!in_range(i_rd_addr[c]))  r_rd_data[c] <= '0;
          else if (r_front_sel)         r_rd_data[c] <= r_bank1[i_rd_addr[c][IW-1:0]];
          else                          r_rd_data[c] <= r_bank0[i_rd_addr[c][IW-1:0]];
        end
      end
    end
  end

endmodule

// File: tb/tb_pingpong_sram_array.sv
module tb_pingpong_sram_array;

  localparam int CH = 4;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int DP = 16;
  localparam logic [DW-1:0] CLR = 16'h00FF;

  logic clk = 1'b0;
  logic rst;
  logic [CH-1:0]          wr_en;
  logic [CH-1:0][AW-1:0]  wr_addr;
  logic [CH-1:0][DW-1:0]  wr_data;
  logic                   wr_ready;
  logic [CH-1:0]          rd_en;
  logic [CH-1:0][AW-1:0]  rd_addr;
  logic [CH-1:0][DW-1:0]  rd_data;
  logic [CH-1:0]          rd_valid;
  logic                   flip_req;
  logic                   flip_ack;
  logic                   busy;
  logic                   front_sel;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pingpong_sram_array #(
    .CHANNELS(CH), .DATA_SIZE(DW), .ADDR_SIZE(AW), .DEPTH(DP), .CLEAR_VALUE(CLR)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .i_flip_req(flip_req), .o_flip_ack(flip_ack), .o_busy(busy), .o_front_sel(front_sel)
  );

  typedef struct {
    logic [CH-1:0]          we;
    logic [CH-1:0][AW-1:0]  wa;
    logic [CH-1:0][DW-1:0]  wd;
    logic [CH-1:0]          re;
    logic [CH-1:0][AW-1:0]  ra;
    logic                   flip;
    logic [CH-1:0]          ev;
    logic [CH-1:0][DW-1:0]  ed;
    logic                   efs;
    logic                   eack;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0;
  endtask

  task automatic wait_ack(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (flip_ack === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("ack_within_budget", {31'd0, seen}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flip_req = 1'b0;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    chk("rst_front_sel", {31'd0, front_sel}, 32'd1);
    chk("rst_flip_ack",  {31'd0, flip_ack},  32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_wr_ready",  {31'd0, wr_ready},  32'd1);
    chk("rst_rd_valid",  {28'd0, rd_valid},  32'd0);
    chk("rst_rd_data",   rd_data[0] | rd_data[1] | rd_data[2] | rd_data[3], 32'd0);
  endtask

`ifndef PINGPONG_SRAM_CLEAR_EN
  vec_t tbl [10];
  int   n_ack;
  logic m_ack;
  logic m_fs;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifndef PINGPONG_SRAM_CLEAR_EN
    // bank0 is back after reset; bank1 is front.
    tbl[0] = '{we:4'b0111, wa:{10'd0, 10'd4, 10'd3, 10'd5}, wd:{16'h0, 16'h4444, 16'h3333, 16'h1234},
               re:4'b0, ra:'0, flip:1'b0, ev:4'b0, ed:'0, efs:1'b1, eack:1'b0};
    tbl[1] = '{we:4'b1101, wa:{10'd7, 10'd7, 10'd0, 10'd7}, wd:{16'hCCCC, 16'hBBBB, 16'h0, 16'hAAAA},
               re:4'b0, ra:'0, flip:1'b0, ev:4'b0, ed:'0, efs:1'b1, eack:1'b0};
    tbl[2] = '{we:4'b0110, wa:{10'd0, 10'd15, 10'd20, 10'd0}, wd:{16'h0, 16'h1515, 16'h5555, 16'h0},
               re:4'b0, ra:'0, flip:1'b0, ev:4'b0, ed:'0, efs:1'b1, eack:1'b0};
    tbl[3] = '{we:4'b0, wa:'0, wd:'0, re:4'b0, ra:'0, flip:1'b1,
               ev:4'b0, ed:'0, efs:1'b0, eack:1'b1};
    tbl[4] = '{we:4'b0, wa:'0, wd:'0, re:4'b1111, ra:{10'd15, 10'd20, 10'd7, 10'd5}, flip:1'b0,
               ev:4'b1111, ed:{16'h1515, 16'h0000, 16'hAAAA, 16'h1234}, efs:1'b0, eack:1'b0};
    tbl[5] = '{we:4'b0, wa:'0, wd:'0, re:4'b0010, ra:{10'd0, 10'd0, 10'd4, 10'd0}, flip:1'b0,
               ev:4'b0010, ed:{16'h1515, 16'h0000, 16'h4444, 16'h1234}, efs:1'b0, eack:1'b0};
    tbl[6] = '{we:4'b0010, wa:{10'd0, 10'd0, 10'd3, 10'd0}, wd:{16'h0, 16'h0, 16'h0F0F, 16'h0},
               re:4'b0001, ra:{10'd0, 10'd0, 10'd0, 10'd3}, flip:1'b1,
               ev:4'b0001, ed:{16'h1515, 16'h0000, 16'h4444, 16'h3333}, efs:1'b1, eack:1'b1};
    tbl[7] = '{we:4'b0, wa:'0, wd:'0, re:4'b0001, ra:{10'd0, 10'd0, 10'd0, 10'd3}, flip:1'b0,
               ev:4'b0001, ed:{16'h1515, 16'h0000, 16'h4444, 16'h0F0F}, efs:1'b1, eack:1'b0};
    tbl[8] = '{we:4'b0, wa:'0, wd:'0, re:4'b0, ra:'0, flip:1'b1,
               ev:4'b0, ed:{16'h1515, 16'h0000, 16'h4444, 16'h0F0F}, efs:1'b0, eack:1'b1};
    tbl[9] = '{we:4'b0, wa:'0, wd:'0, re:4'b0001, ra:{10'd0, 10'd0, 10'd0, 10'd3}, flip:1'b0,
               ev:4'b0001, ed:{16'h1515, 16'h0000, 16'h4444, 16'h3333}, efs:1'b0, eack:1'b0};
`endif

    do_reset();

`ifndef PINGPONG_SRAM_CLEAR_EN
    for (int i = 0; i < 10; i++) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rd_en = tbl[i].re; rd_addr = tbl[i].ra; flip_req = tbl[i].flip;
      step();
      chk($sformatf("v%0d_rd_valid", i), {28'd0, rd_valid}, {28'd0, tbl[i].ev});
      for (int c = 0; c < CH; c++)
        chk($sformatf("v%0d_rd_data%0d", i, c), {16'd0, rd_data[c]}, {16'd0, tbl[i].ed[c]});
      chk($sformatf("v%0d_front_sel", i), {31'd0, front_sel}, {31'd0, tbl[i].efs});
      chk($sformatf("v%0d_flip_ack", i),  {31'd0, flip_ack},  {31'd0, tbl[i].eack});
      chk($sformatf("v%0d_wr_ready", i),  {31'd0, wr_ready},  32'd1);
      chk($sformatf("v%0d_busy", i),      {31'd0, busy},      32'd0);
    end
    idle_inputs();
    flip_req = 1'b0;

    // Request held for 10 edges: IDLE/ACK alternate, one accept every 2 edges.
    n_ack = 0;
    m_ack = 1'b0;
    m_fs  = 1'b0;
    flip_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      m_ack = ~m_ack;
      if (m_ack) m_fs = ~m_fs;
      if (flip_ack === 1'b1) n_ack++;
      chk($sformatf("held_ack%0d", i), {31'd0, flip_ack}, {31'd0, m_ack});
    end
    flip_req = 1'b0;
    chk("held_ack_count", n_ack, 32'd5);
    chk("held_front_sel", {31'd0, front_sel}, {31'd0, m_fs});
    step();
    chk("held_no_extra_ack", {31'd0, flip_ack}, 32'd0);

    // Async reset during the ACK cycle kills the ack and restores front_sel.
    flip_req = 1'b1;
    step();
    flip_req = 1'b0;
    chk("rack_pre_ack", {31'd0, flip_ack}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rack_ack_killed", {31'd0, flip_ack},  32'd0);
    chk("rack_front_sel",  {31'd0, front_sel}, 32'd1);
    chk("rack_rd_valid",   {28'd0, rd_valid},  32'd0);
    step();
    rst = 1'b0;
    flip_req = 1'b1;
    wait_ack(4);
    flip_req = 1'b0;
    chk("rack_recover_fs", {31'd0, front_sel}, 32'd0);
    step();
`else
    // bank0 is back: seed addr 2, then flip with clear.
    wr_en = 4'b0001; wr_addr[0] = 10'd2; wr_data[0] = 16'h2222;
    step();
    idle_inputs();
    flip_req = 1'b1;
    step();
    for (int i = 1; i <= DP; i++) begin
      chk($sformatf("clr_busy_c%0d", i),  {31'd0, busy},     32'd1);
      chk($sformatf("clr_ready_c%0d", i), {31'd0, wr_ready}, 32'd0);
      chk($sformatf("clr_ack_c%0d", i),   {31'd0, flip_ack}, 32'd0);
      wr_en = (i == 12) ? 4'b0001 : 4'b0000;
      wr_addr[0] = 10'd0; wr_data[0] = 16'hDEAD;
      step();
    end
    idle_inputs();
    chk("clr_ack_c17",   {31'd0, flip_ack},  32'd1);
    chk("clr_busy_c17",  {31'd0, busy},      32'd0);
    chk("clr_ready_c17", {31'd0, wr_ready},  32'd1);
    chk("clr_front_sel", {31'd0, front_sel}, 32'd0);
    flip_req = 1'b0;
    rd_en = 4'b0001; rd_addr[0] = 10'd2;
    step();
    rd_en = '0;
    chk("clr_front_keeps", {16'd0, rd_data[0]}, 32'h2222);

    // Second flip: bank1 (cleared, write during busy dropped) becomes front.
    flip_req = 1'b1;
    wait_ack(DP + 4);
    flip_req = 1'b0;
    chk("clr2_front_sel", {31'd0, front_sel}, 32'd1);
    for (int g = 0; g < DP / CH; g++) begin
      rd_en = '1;
      for (int c = 0; c < CH; c++) rd_addr[c] = AW'(g * CH + c);
      step();
      for (int c = 0; c < CH; c++)
        chk($sformatf("clr_word%0d", g * CH + c), {16'd0, rd_data[c]}, {16'd0, CLR});
    end
    rd_en = '0;

    // Reset in cycle 4 of the clear.
    flip_req = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("rclr_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    flip_req = 1'b0;
    #1;
    chk("rclr_busy",      {31'd0, busy},      32'd0);
    chk("rclr_ack",       {31'd0, flip_ack},  32'd0);
    chk("rclr_front_sel", {31'd0, front_sel}, 32'd1);
    chk("rclr_wr_ready",  {31'd0, wr_ready},  32'd1);
    step();
    rst = 1'b0;
    step();
    chk("rclr_no_ack", {31'd0, flip_ack}, 32'd0);
    flip_req = 1'b1;
    wait_ack(DP + 4);
    flip_req = 1'b0;
    chk("rclr_recover_fs", {31'd0, front_sel}, 32'd0);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
